// File: rtl/hazard_pkg.sv
// Shared types and helpers for the EX-stage forwarding / load-use unit.
// Slot tags are stored at MAX_AW bits so one struct serves every REG_AW.
package hazard_pkg;

  localparam int MAX_AW        = 8;
  localparam int MAX_SLOTS     = 8;
  localparam int FWD_RF        = 0;
  localparam int FWD_SLOT_BASE = 1;

  typedef struct packed {
    logic              valid;
    logic [MAX_AW-1:0] rd;
    logic              regwrite;
    logic              is_load;
  } slot_t;

  function automatic int prio_match(
    input logic [MAX_SLOTS-1:0] hit
  );
    int sel;
    sel = FWD_RF;
    for (int k = MAX_SLOTS - 1; k >= 0; k--) begin
      if (hit[k]) sel = FWD_SLOT_BASE + k;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-facing bundle of the forwarding / hazard unit.
// master = pipeline control side, slave = hazard unit.
interface hazard_forward_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 2
);

  logic                      advance;
  logic                      flush;
  logic                      ex_valid;
  logic [REG_AW-1:0]         ex_rd;
  logic                      ex_regwrite;
  logic                      ex_is_load;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic [15:0]               stall_count;

  modport master (
    output advance, flush,
    output ex_valid, ex_rd, ex_regwrite,
    output ex_is_load, ex_rs,
    output id_valid, id_rs,
    input  fwd_sel, stall, stall_count
  );

  modport slave (
    input  advance, flush,
    input  ex_valid, ex_rd, ex_regwrite,
    input  ex_is_load, ex_rs,
    input  id_valid, id_rs,
    output fwd_sel, stall, stall_count
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_tag_pipe.sv
// Shadow shift register of destination tags for instructions past EX.
// Slot 0 is EX/Mem; a flush turns the entering tag into a bubble.
module fwd_tag_pipe
  import hazard_pkg::*;
#(
  parameter int FWD_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  input  logic flush,
  input  slot_t ex_slot,
  output logic [FWD_DEPTH*$bits(slot_t)-1:0] slots_flat
);

  slot_t [FWD_DEPTH-1:0] q;
  slot_t                 entry;

  always_comb begin
    entry       = ex_slot;
    entry.valid = ex_slot.valid & ~flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (advance) begin
      q[0] <= entry;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        q[k] <= q[k-1];
      end
    end
  end

  assign slots_flat = q;

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding select and load-use stall generation.
// Youngest matching producer wins; stall cycles counted, saturating.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input logic clk,
  input logic reset,
  hazard_forward_unit_if.slave bus
);

  slot_t                              ex_slot;
  slot_t [FWD_DEPTH-1:0]              slots;
  logic [FWD_DEPTH*$bits(slot_t)-1:0] slots_flat;
  logic [NUM_SRC*SEL_W-1:0]           fwd_sel;
  logic [NUM_SRC-1:0]                 escape;
  logic [MAX_SLOTS-1:0]               hit;
  logic [REG_AW-1:0]                  rs;
  logic [REG_AW-1:0]                  id_src;
  logic                               found;
  logic                               ld_use;
  logic                               ex_load_prod;
  logic                               stall;
  logic [15:0]                        stall_count;

  always_comb begin
    ex_slot          = '0;
    ex_slot.valid    = bus.ex_valid;
    ex_slot.rd       = MAX_AW'(bus.ex_rd);
    ex_slot.regwrite = bus.ex_regwrite;
    ex_slot.is_load  = bus.ex_is_load;
  end

  fwd_tag_pipe #(
    .FWD_DEPTH(FWD_DEPTH)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .advance   (bus.advance),
    .flush     (bus.flush),
    .ex_slot   (ex_slot),
    .slots_flat(slots_flat)
  );

  assign slots = slots_flat;

  function automatic logic produces(
    input slot_t             t,
    input logic [REG_AW-1:0] r
  );
    return t.valid && t.regwrite &&
           (t.rd != '0) && (t.rd == MAX_AW'(r));
  endfunction

  always_comb begin
    fwd_sel = '0;
    escape  = '0;
    hit     = '0;
    rs      = '0;
    found   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      rs    = bus.ex_rs[s*REG_AW +: REG_AW];
      hit   = '0;
      found = 1'b0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        hit[k] = produces(slots[k], rs);
        // winner too young to carry load data => escaped hazard
        if (!found && hit[k]) begin
          found     = 1'b1;
          escape[s] = (k < LOAD_LAT) && slots[k].is_load;
        end
      end
      fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(prio_match(hit));
    end
  end

  assign ex_load_prod = bus.ex_valid && bus.ex_regwrite &&
                        bus.ex_is_load && (bus.ex_rd != '0);

  always_comb begin
    ld_use = 1'b0;
    id_src = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      id_src = bus.id_rs[s*REG_AW +: REG_AW];
      if (LOAD_LAT >= 1 && ex_load_prod &&
          bus.ex_rd == id_src) begin
        ld_use = 1'b1;
      end
      for (int k = 0; k < FWD_DEPTH; k++) begin
        if (k + 1 < LOAD_LAT && slots[k].is_load &&
            produces(slots[k], id_src)) begin
          ld_use = 1'b1;
        end
      end
    end
  end

  // reset masks the EX-input term so stall drops at once
  assign stall = !reset && bus.id_valid && ld_use;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign bus.fwd_sel     = fwd_sel;
  assign bus.stall       = stall;
  assign bus.stall_count = stall_count;

`ifndef SYNTHESIS
  a_no_escape: assert property (
    @(posedge clk) disable iff (reset)
      !(bus.ex_valid && |escape)
  );
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: default and deep configs.
// Each task drives one scenario and checks inline.
module tb_hazard_forward_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(5), .NUM_SRC(2), .SEL_W(2)) bus_a ();
  hazard_forward_unit_if #(.REG_AW(5), .NUM_SRC(2), .SEL_W(2)) bus_b ();

  hazard_forward_unit #(
    .REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(2), .LOAD_LAT(1)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  hazard_forward_unit #(
    .REG_AW(5), .NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(2)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_a(input logic v, input logic [4:0] rd,
                      input logic rw, input logic ld,
                      input logic [4:0] rs1, input logic [4:0] rs0);
    bus_a.ex_valid    = v;
    bus_a.ex_rd       = rd;
    bus_a.ex_regwrite = rw;
    bus_a.ex_is_load  = ld;
    bus_a.ex_rs       = {rs1, rs0};
  endtask

  task automatic ex_b(input logic v, input logic [4:0] rd,
                      input logic rw, input logic ld,
                      input logic [4:0] rs1, input logic [4:0] rs0);
    bus_b.ex_valid    = v;
    bus_b.ex_rd       = rd;
    bus_b.ex_regwrite = rw;
    bus_b.ex_is_load  = ld;
    bus_b.ex_rs       = {rs1, rs0};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ex_a(0, 0, 0, 0, 0, 0);
    ex_b(0, 0, 0, 0, 0, 0);
    bus_a.advance = 0; bus_a.flush = 0;
    bus_a.id_valid = 0; bus_a.id_rs = '0;
    bus_b.advance = 0; bus_b.flush = 0;
    bus_b.id_valid = 0; bus_b.id_rs = '0;
    #3;
    n_cmp++;
    if (bus_a.fwd_sel !== 4'd0) begin
      n_err++;
      $display("FAIL rst_fwd_sel got %0h want 0", bus_a.fwd_sel);
    end
    n_cmp++;
    if (bus_a.stall !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stall got %b want 0", bus_a.stall);
    end
    n_cmp++;
    if (bus_a.stall_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_count_a got %0h want 0", bus_a.stall_count);
    end
    n_cmp++;
    if (bus_b.stall_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_count_b got %0h want 0", bus_b.stall_count);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_exmem();
    ex_a(1, 5, 1, 0, 0, 0);
    bus_a.advance = 1;
    step();
    ex_a(1, 0, 0, 0, 0, 5);
    #1;
    n_cmp++;
    if (bus_a.fwd_sel[1:0] !== 2'd1) begin
      n_err++;
      $display("FAIL exmem_slot0 got %0d want 1", bus_a.fwd_sel[1:0]);
    end
    n_cmp++;
    if (bus_a.fwd_sel[3:2] !== 2'd0) begin
      n_err++;
      $display("FAIL exmem_src1_rf got %0d want 0", bus_a.fwd_sel[3:2]);
    end
    step();
    n_cmp++;
    if (bus_a.fwd_sel[1:0] !== 2'd2) begin
      n_err++;
      $display("FAIL exmem_slot1 got %0d want 2", bus_a.fwd_sel[1:0]);
    end
    step();
    n_cmp++;
    if (bus_a.fwd_sel[1:0] !== 2'd0) begin
      n_err++;
      $display("FAIL exmem_retired got %0d want 0", bus_a.fwd_sel[1:0]);
    end
  endtask

  task automatic test_youngest();
    ex_a(1, 7, 1, 0, 0, 0);
    bus_a.advance = 1;
    step();
    step();
    bus_a.advance = 0;
    ex_a(1, 0, 0, 0, 7, 0);
    #1;
    n_cmp++;
    if (bus_a.fwd_sel[3:2] !== 2'd1) begin
      n_err++;
      $display("FAIL youngest got %0d want 1", bus_a.fwd_sel[3:2]);
    end
    ex_a(1, 0, 1, 0, 0, 0);
    bus_a.advance = 1;
    step();
    bus_a.advance = 0;
    ex_a(1, 0, 0, 0, 7, 0);
    #1;
    n_cmp++;
    if (bus_a.fwd_sel[1:0] !== 2'd0) begin
      n_err++;
      $display("FAIL x0_no_fwd got %0d want 0", bus_a.fwd_sel[1:0]);
    end
    n_cmp++;
    if (bus_a.fwd_sel[3:2] !== 2'd2) begin
      n_err++;
      $display("FAIL x7_slot1 got %0d want 2", bus_a.fwd_sel[3:2]);
    end
    ex_a(0, 0, 0, 0, 0, 0);
    bus_a.advance = 1;
    step();
    step();
    bus_a.advance = 0;
  endtask

  task automatic test_load_use();
    ex_a(1, 3, 1, 1, 0, 0);
    bus_a.id_valid = 1;
    bus_a.id_rs    = {5'd0, 5'd3};
    bus_a.advance  = 1;
    #1;
    n_cmp++;
    if (bus_a.stall !== 1'b1) begin
      n_err++;
      $display("FAIL lu_stall got %b want 1", bus_a.stall);
    end
    n_cmp++;
    if (bus_a.stall_count !== 16'd0) begin
      n_err++;
      $display("FAIL lu_count0 got %0d want 0", bus_a.stall_count);
    end
    step();
    ex_a(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (bus_a.stall !== 1'b0) begin
      n_err++;
      $display("FAIL lu_bubble_stall got %b want 0", bus_a.stall);
    end
    n_cmp++;
    if (bus_a.stall_count !== 16'd1) begin
      n_err++;
      $display("FAIL lu_count1 got %0d want 1", bus_a.stall_count);
    end
    step();
    ex_a(1, 0, 0, 0, 0, 3);
    bus_a.id_valid = 0;
    #1;
    n_cmp++;
    if (bus_a.fwd_sel[1:0] !== 2'd2) begin
      n_err++;
      $display("FAIL lu_memwb got %0d want 2", bus_a.fwd_sel[1:0]);
    end
    n_cmp++;
    if (bus_a.stall_count !== 16'd1) begin
      n_err++;
      $display("FAIL lu_count_hold got %0d want 1", bus_a.stall_count);
    end
    ex_a(0, 0, 0, 0, 0, 0);
    step();
    step();
    bus_a.advance = 0;
  endtask

  task automatic test_flush_hold();
    ex_a(1, 9, 1, 0, 0, 0);
    bus_a.flush   = 1;
    bus_a.advance = 1;
    step();
    bus_a.flush   = 0;
    bus_a.advance = 0;
    ex_a(1, 0, 0, 0, 0, 9);
    #1;
    n_cmp++;
    if (bus_a.fwd_sel[1:0] !== 2'd0) begin
      n_err++;
      $display("FAIL flush_bubble got %0d want 0", bus_a.fwd_sel[1:0]);
    end
    ex_a(1, 9, 1, 0, 0, 0);
    bus_a.advance = 1;
    step();
    bus_a.advance = 0;
    bus_a.flush   = 1;
    ex_a(1, 0, 0, 0, 9, 9);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      else #1;
      n_cmp++;
      if (bus_a.fwd_sel !== 4'b0101) begin
        n_err++;
        $display("FAIL hold_c%0d got %0h want 5", c, bus_a.fwd_sel);
      end
    end
    bus_a.flush = 0;
    ex_a(0, 0, 0, 0, 0, 0);
    bus_a.advance = 1;
    step();
    step();
    bus_a.advance = 0;
  endtask

  task automatic test_depth3();
    ex_b(1, 4, 1, 1, 0, 0);
    bus_b.id_valid = 1;
    bus_b.id_rs    = {5'd4, 5'd0};
    bus_b.advance  = 1;
    #1;
    n_cmp++;
    if (bus_b.stall !== 1'b1) begin
      n_err++;
      $display("FAIL d3_ex_stall got %b want 1", bus_b.stall);
    end
    step();
    ex_b(0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++;
    if (bus_b.stall !== 1'b1) begin
      n_err++;
      $display("FAIL d3_slot0_stall got %b want 1", bus_b.stall);
    end
    step();
    ex_b(0, 0, 0, 0, 0, 4);
    #1;
    n_cmp++;
    if (bus_b.stall !== 1'b0) begin
      n_err++;
      $display("FAIL d3_slot1_stall got %b want 0", bus_b.stall);
    end
    n_cmp++;
    if (bus_b.fwd_sel[1:0] !== 2'd2) begin
      n_err++;
      $display("FAIL d3_slot1_sel got %0d want 2", bus_b.fwd_sel[1:0]);
    end
    step();
    ex_b(1, 0, 0, 0, 4, 0);
    bus_b.id_valid = 0;
    #1;
    n_cmp++;
    if (bus_b.fwd_sel[3:2] !== 2'd3) begin
      n_err++;
      $display("FAIL d3_slot2_sel got %0d want 3", bus_b.fwd_sel[3:2]);
    end
    n_cmp++;
    if (bus_b.stall_count !== 16'd2) begin
      n_err++;
      $display("FAIL d3_count got %0d want 2", bus_b.stall_count);
    end
    ex_b(0, 0, 0, 0, 0, 0);
    step();
    step();
    step();
    bus_b.advance = 0;
  endtask

  task automatic test_saturation();
    ex_a(1, 8, 1, 0, 0, 0);
    bus_a.advance = 1;
    step();
    bus_a.advance = 0;
    ex_a(1, 3, 1, 1, 0, 8);
    bus_a.id_valid = 1;
    bus_a.id_rs    = {5'd0, 5'd3};
    #1;
    n_cmp++;
    if (bus_a.stall !== 1'b1 || bus_a.fwd_sel[1:0] !== 2'd1) begin
      n_err++;
      $display("FAIL sat_setup got stall=%b sel=%0d want 1/1",
               bus_a.stall, bus_a.fwd_sel[1:0]);
    end
    // count is 1 from the load-use scenario; climb to FFFE
    repeat (65533) @(posedge clk);
    #1;
    n_cmp++;
    if (bus_a.stall_count !== 16'hFFFE) begin
      n_err++;
      $display("FAIL sat_fffe got %0h want fffe", bus_a.stall_count);
    end
    step();
    n_cmp++;
    if (bus_a.stall_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_ffff got %0h want ffff", bus_a.stall_count);
    end
    step();
    n_cmp++;
    if (bus_a.stall_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_nowrap got %0h want ffff", bus_a.stall_count);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus_a.stall_count !== 16'd0) begin
      n_err++;
      $display("FAIL mid_rst_count got %0h want 0", bus_a.stall_count);
    end
    n_cmp++;
    if (bus_a.stall !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_stall got %b want 0", bus_a.stall);
    end
    n_cmp++;
    if (bus_a.fwd_sel !== 4'd0) begin
      n_err++;
      $display("FAIL mid_rst_sel got %0h want 0", bus_a.fwd_sel);
    end
    #2;
    reset = 1'b0;
    bus_a.id_valid = 0;
    ex_a(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_exmem();
    test_youngest();
    test_load_use();
    test_flush_hold();
    test_depth3();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
